// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding, reset PC default and word-width constants.
package pc_fetch_pkg;
    localparam int WORD_W = 32;
    localparam int INSTR_W = 32;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int DEFAULT_IMEM_TIMEOUT = 16;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        HALT,
        FAULT
    } state_t;
endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC select: jump/jal target, taken branch, or sequential.
// Zero latency; no flow control.
module pc_next_sel
    import pc_fetch_pkg::*;
(
    input  logic [WORD_W-1:0]  pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               jump,
    input  logic               jal,
    input  logic               branch,
    input  logic               bne,
    input  logic               zero,
    output logic [WORD_W-1:0]  next_pc
);
    logic [WORD_W-1:0] br_off;
    logic              taken;

    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign taken  = branch & (bne ? ~zero : zero);

    always_comb begin
        next_pc = pc_plus4;
        if (jump || jal) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + br_off;
        end
    end
endmodule

// File: rtl/pc_fetch.sv
// Fetch/issue sequencer: requests a word from imem, presents it for one ISSUE cycle, then advances PC.
// Instruction visible the cycle after imem_ready; stall extends ISSUE; halts on unknown opcode or imem timeout.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int                IMEM_TIMEOUT = DEFAULT_IMEM_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [WORD_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [WORD_W-1:0]  pc,
    output logic [WORD_W-1:0]  pc_plus4,
    input  logic               Jump,
    input  logic               Jal,
    input  logic               Branch,
    input  logic               BNE,
    input  logic               UnknownOpcode,
    input  logic               zero,
    input  logic               stall,
    output logic               halted,
    output logic               fault,
    output logic [WORD_W-1:0]  retired
);
    localparam int TW = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(IMEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [TW-1:0]      tmo_q, tmo_d, tmo_inc;
    logic [WORD_W-1:0]  pc_q, retired_q, next_pc;
    logic [INSTR_W-1:0] instr_q;
    logic               load_instr, advance;

    assign pc_plus4  = pc_q + PC_STEP;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign tmo_inc   = tmo_q + 1'b1;

    pc_next_sel u_next_sel (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .jump     (Jump),
        .jal      (Jal),
        .branch   (Branch),
        .bne      (BNE),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        load_instr = 1'b0;
        advance    = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    load_instr = 1'b1;
                    tmo_d      = '0;
                    state_d    = ISSUE;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        state_d = FAULT;
                    end
                end
            end
            ISSUE: begin
                // An unknown opcode halts even if the datapath is stalling.
                if (UnknownOpcode) begin
                    state_d = HALT;
                end else if (!stall) begin
                    advance = 1'b1;
                    state_d = FETCH;
                end
            end
            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = state_q;
        endcase
    end

    // imem_req is gated by reset so it stays low while reset is held.
    assign imem_req    = (state_q == FETCH) && !reset;
    assign instr_valid = (state_q == ISSUE);
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            tmo_q     <= '0;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (load_instr) begin
                instr_q <= imem_rdata;
            end
            if (advance) begin
                pc_q      <= next_pc;
                retired_q <= retired_q + 32'd1;
            end
        end
    end
endmodule
